// File: rtl/door_controller.sv
// Per-car door sequencer: drives the door motor from limit switches and cabin inputs,
// reports closed/open back to the elevator controller and latches stuck-door/sensor faults.
module door_controller #(
  parameter int OPEN_HOLD_CYCLES = 100,
  parameter int MOTION_TIMEOUT   = 50,
  parameter int MAX_REOPEN       = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic up,
  input  logic down,
  input  logic stop,
  input  logic open_btn,
  input  logic close_btn,
  input  logic obstruction,
  input  logic open_limit,
  input  logic closed_limit,
  output logic door_status,
  output logic motor_open,
  output logic motor_close,
  output logic door_fault
);

  localparam int TIMER_MAX = (OPEN_HOLD_CYCLES > MOTION_TIMEOUT) ? OPEN_HOLD_CYCLES : MOTION_TIMEOUT;
  localparam int TIMER_W   = (TIMER_MAX < 1) ? 1 : $clog2(TIMER_MAX + 1);
  localparam int REOPEN_W  = (MAX_REOPEN < 1) ? 1 : $clog2(MAX_REOPEN + 1);

  localparam logic [TIMER_W-1:0]  HOLD_LOAD    = TIMER_W'(OPEN_HOLD_CYCLES);
  localparam logic [TIMER_W-1:0]  MOTION_LOAD  = TIMER_W'(MOTION_TIMEOUT);
  localparam logic [REOPEN_W-1:0] REOPEN_LIMIT = REOPEN_W'(MAX_REOPEN);

  typedef enum logic [2:0] {
    ST_CLOSED    = 3'd0,
    ST_OPENING   = 3'd1,
    ST_OPEN_HOLD = 3'd2,
    ST_CLOSING   = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic [REOPEN_W-1:0] reopen_cnt_reg, reopen_cnt_next;

  logic [TIMER_W-1:0]  timer_dec;
  logic [REOPEN_W-1:0] reopen_inc;
  logic                sensor_conflict;
  logic                hold_request;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_CLOSED;
      timer_reg      <= '0;
      reopen_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      reopen_cnt_reg <= reopen_cnt_next;
    end
  end

  // Both counters saturate rather than wrap.
  assign timer_dec  = (timer_reg == '0) ? '0 : timer_reg - TIMER_W'(1);
  assign reopen_inc = (reopen_cnt_reg == REOPEN_LIMIT) ? reopen_cnt_reg
                                                       : reopen_cnt_reg + REOPEN_W'(1);

  // Both limit switches at once is physically impossible: treat as a broken sensor.
  assign sensor_conflict = open_limit & closed_limit;
  assign hold_request    = obstruction | open_btn;

  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    reopen_cnt_next = reopen_cnt_reg;

    if (state_reg != ST_FAULT && sensor_conflict) begin
      state_next = ST_FAULT;
    end else begin
      case (state_reg)
        ST_CLOSED: begin
          // A moving or not-yet-stopped car never opens, whatever the cabin buttons say.
          if (stop && !up && !down) begin
            state_next = ST_OPENING;
            timer_next = MOTION_LOAD;
          end
        end

        ST_OPENING: begin
          if (open_limit) begin
            state_next = ST_OPEN_HOLD;
            timer_next = HOLD_LOAD;
          end else begin
            timer_next = timer_dec;
            if (timer_dec == '0) begin
              state_next = ST_FAULT;
            end
          end
        end

        ST_OPEN_HOLD: begin
          if (hold_request) begin
            timer_next = HOLD_LOAD;
          end else if (close_btn || timer_dec == '0) begin
            state_next = ST_CLOSING;
            timer_next = MOTION_LOAD;
          end else begin
            timer_next = timer_dec;
          end
        end

        ST_CLOSING: begin
          // A reopen request outranks closed_limit seen in the same cycle.
          if (hold_request) begin
            reopen_cnt_next = reopen_inc;
            if (reopen_inc == REOPEN_LIMIT) begin
              state_next = ST_FAULT;
            end else begin
              state_next = ST_OPENING;
              timer_next = MOTION_LOAD;
            end
          end else if (closed_limit) begin
            state_next      = ST_CLOSED;
            reopen_cnt_next = '0;
          end else begin
            timer_next = timer_dec;
            if (timer_dec == '0) begin
              state_next = ST_FAULT;
            end
          end
        end

        ST_FAULT: begin
          state_next = ST_FAULT;
        end

        default: begin
          state_next = ST_FAULT;
        end
      endcase
    end
  end

  // Moore outputs; FAULT reports "open" so the controller keeps the car parked.
  always_comb begin
    door_status = (state_reg == ST_CLOSED);
    motor_open  = (state_reg == ST_OPENING);
    motor_close = (state_reg == ST_CLOSING);
    door_fault  = (state_reg == ST_FAULT);
  end

endmodule
